// File: rtl/lea_pkg.sv
// Purpose: shared constants and FSM state type for the LEA nibble-serial subtract scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lea_pkg;

    localparam int LEA_WORD_W = 32;
    localparam int LEA_DIG_W  = 4;
    localparam int LEA_NDIG   = LEA_WORD_W / LEA_DIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : lea_pkg

// File: rtl/lea_digit_sub.sv
// Purpose: one DIG_W-bit digit of a borrow-chained subtractor, {bout, d} = a - b - bin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports:
//   a, b  : minuend / subtrahend digit
//   bin   : borrow in from the previous (less significant) digit
//   d     : difference digit
//   bout  : borrow out, 1 when a < b + bin
module lea_digit_sub #(
    parameter int DIG_W = 4
) (
    input  logic [DIG_W-1:0] a,
    input  logic [DIG_W-1:0] b,
    input  logic             bin,
    output logic [DIG_W-1:0] d,
    output logic             bout
);

    // A one-bit extension catches the borrow: the top bit of the result goes
    // high exactly when the unsigned difference would be negative.
    always_comb begin
        {bout, d} = {1'b0, a} - {1'b0, b} - {{DIG_W{1'b0}}, bin};
    end

endmodule : lea_digit_sub

// File: rtl/lea_sub_sched.sv
// Purpose: shares one digit subtractor between two requesters, computing (A - B) mod 2^WORD_W digit-serially.
// Latency: result valid NDIG cycles after the grant edge; minimum issue interval NDIG+2 cycles.
// Backpressure: result held in DONE until res_ready; no request accepted while busy or result unconsumed.
//
// Ports:
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   req_valid / req_ready : per-requester handshake (bit i = requester i), ready is one-hot or zero
//   req_a0/req_b0,
//   req_a1/req_b1         : operands of requester 0 / 1, sampled only on the grant edge
//   res_valid / res_ready : result handshake
//   res_data              : (A - B) mod 2^WORD_W
//   res_borrow            : final borrow, 1 when A < B unsigned
//   res_id                : requester that issued the result
module lea_sub_sched
    import lea_pkg::*;
#(
    parameter int WORD_W = LEA_WORD_W,
    parameter int DIG_W  = LEA_DIG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WORD_W-1:0] req_a0,
    input  logic [WORD_W-1:0] req_b0,
    input  logic [WORD_W-1:0] req_a1,
    input  logic [WORD_W-1:0] req_b1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_data,
    output logic              res_borrow,
    output logic              res_id
);

    // The shift datapath below assumes at least two digits per word.
    localparam int NDIG  = WORD_W / DIG_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [WORD_W-1:0] res_data_q, res_data_d;
    logic              borrow_q, borrow_d;
    logic              res_id_q, res_id_d;
    logic              last_grant_q, last_grant_d;

    logic [1:0]        gnt;
    logic [DIG_W-1:0]  dig_d;
    logic              dig_bout;

    // Operands are shifted right each RUN cycle, so the current digit is
    // always the low digit of the registers; cnt only tracks progress.
    lea_digit_sub #(
        .DIG_W (DIG_W)
    ) u_digit_sub (
        .a    (a_q[DIG_W-1:0]),
        .b    (b_q[DIG_W-1:0]),
        .bin  (borrow_q),
        .d    (dig_d),
        .bout (dig_bout)
    );

    // Round-robin arbiter: on a tie, the requester not granted last wins;
    // a lone requester wins regardless of history.
    always_comb begin
        gnt = 2'b00;
        if (state_q == IDLE && !rst) begin
            gnt[0] = req_valid[0] & (~req_valid[1] | last_grant_q);
            gnt[1] = req_valid[1] & (~req_valid[0] | ~last_grant_q);
        end
    end

    assign req_ready  = gnt;
    assign res_valid  = (state_q == DONE);
    assign res_data   = res_data_q;
    assign res_borrow = borrow_q;
    assign res_id     = res_id_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        res_data_d   = res_data_q;
        borrow_d     = borrow_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;

        unique case (state_q)
            IDLE: begin
                if (gnt[0]) begin
                    a_d = req_a0;
                    b_d = req_b0;
                end else if (gnt[1]) begin
                    a_d = req_a1;
                    b_d = req_b1;
                end
                if (|gnt) begin
                    cnt_d        = '0;
                    borrow_d     = 1'b0;
                    res_id_d     = gnt[1];
                    last_grant_d = gnt[1];
                    state_d      = RUN;
                end
            end
            RUN: begin
                a_d        = a_q >> DIG_W;
                b_d        = b_q >> DIG_W;
                // New digit enters at the top; after NDIG shifts digit 0
                // has reached the bottom of the word.
                res_data_d = {dig_d, res_data_q[WORD_W-1:DIG_W]};
                borrow_d   = dig_bout;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_data_q   <= '0;
            borrow_q     <= 1'b0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_data_q   <= res_data_d;
            borrow_q     <= borrow_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule : lea_sub_sched

// File: tb/tb_lea_sub_sched.sv
module tb_lea_sub_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_borrow;
    logic        res_id;

    typedef struct {
        logic [31:0] data;
        logic        borrow;
        logic        id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    lea_sub_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_borrow (res_borrow),
        .res_id     (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b, input logic id);
        exp_t e;
        e.data   = a - b;
        e.borrow = (a < b);
        e.id     = id;
        return e;
    endfunction

    // Called at the accept-cycle sample point. On the first following
    // sample it applies the new request inputs, then counts samples until
    // res_valid appears (cycles = samples seen with res_valid low).
    task automatic wait_result(input logic [1:0] vld_next, input logic [31:0] a0_next,
                               output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) begin
                req_valid = vld_next;
                req_a0    = a0_next;
            end
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        res_ready = 1'b1;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
        end
        n_checks++;
        if ({res_valid, res_data, res_borrow, res_id} !== 35'd0) begin
            n_fail++; $display("FAIL reset_res: got v=%b d=%h b=%b id=%b want all 0",
                               res_valid, res_data, res_borrow, res_id);
        end
        req_valid = 2'b00;
        rst       = 1'b0;
    endtask

    task automatic test_basic();
        int   cyc;
        bit   ok;
        exp_t e;
        @(negedge clk);
        req_a0 = 32'h8; req_b0 = 32'h4; req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL basic_ready: got %b want 01", req_ready);
        end
        sb.push_back(mk_exp(32'h8, 32'h4, 1'b0));
        wait_result(2'b00, req_a0, cyc, ok);
        n_checks++;
        if (!ok || cyc != 8) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles (valid seen=%0d) want 8", cyc, ok);
        end
        e = sb.pop_front();
        n_checks++;
        if (res_data !== e.data || res_borrow !== e.borrow || res_id !== e.id) begin
            n_fail++; $display("FAIL basic_result: got %h/%b/%b want %h/%b/%b",
                               res_data, res_borrow, res_id, e.data, e.borrow, e.id);
        end
    endtask

    task automatic test_borrow_ripple();
        int   cyc;
        bit   ok;
        exp_t e;
        @(negedge clk);
        req_a1 = 32'h0; req_b1 = 32'h1; req_valid = 2'b10;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++; $display("FAIL ripple_ready: got %b want 10", req_ready);
        end
        sb.push_back(mk_exp(32'h0, 32'h1, 1'b1));
        wait_result(2'b00, req_a0, cyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || res_data !== e.data || res_borrow !== e.borrow || res_id !== e.id) begin
            n_fail++; $display("FAIL ripple_result: got %h/%b/%b want %h/%b/%b",
                               res_data, res_borrow, res_id, e.data, e.borrow, e.id);
        end
    endtask

    task automatic test_round_robin();
        int         cyc;
        bit         ok;
        exp_t       e;
        logic [1:0] want_gnt [3] = '{2'b01, 2'b10, 2'b01};
        @(negedge clk);
        req_a0 = 32'h8; req_b0 = 32'hE; req_a1 = 32'h6; req_b1 = 32'h6;
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++;
            if (req_ready !== want_gnt[i]) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, want_gnt[i]);
            end
            if (want_gnt[i][1]) sb.push_back(mk_exp(32'h6, 32'h6, 1'b1));
            else                sb.push_back(mk_exp(32'h8, 32'hE, 1'b0));
            wait_result((i == 2) ? 2'b00 : 2'b11, req_a0, cyc, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || res_data !== e.data || res_borrow !== e.borrow || res_id !== e.id) begin
                n_fail++; $display("FAIL rr_result%0d: got %h/%b/%b want %h/%b/%b", i,
                                   res_data, res_borrow, res_id, e.data, e.borrow, e.id);
            end
        end
    endtask

    task automatic test_back_pressure();
        int          cyc;
        bit          ok;
        exp_t        e;
        logic [31:0] hold_d;
        logic        hold_b, hold_id;
        @(negedge clk);
        res_ready = 1'b0;
        req_a0 = 32'h10; req_b0 = 32'h3; req_a1 = 32'h20; req_b1 = 32'h20;
        req_valid = 2'b01;
        #1;
        sb.push_back(mk_exp(32'h10, 32'h3, 1'b0));
        // Requester 1 becomes pending while requester 0 is in flight.
        wait_result(2'b10, req_a0, cyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || res_data !== e.data || res_borrow !== e.borrow || res_id !== e.id) begin
            n_fail++; $display("FAIL bp_result: got %h/%b/%b want %h/%b/%b",
                               res_data, res_borrow, res_id, e.data, e.borrow, e.id);
        end
        hold_d = e.data; hold_b = e.borrow; hold_id = e.id;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== hold_d || res_borrow !== hold_b ||
                res_id !== hold_id || req_ready !== 2'b00) begin
                n_fail++; $display("FAIL bp_stall%0d: got v=%b %h/%b/%b rdy=%b want v=1 %h/%b/%b rdy=00",
                                   i, res_valid, res_data, res_borrow, res_id, req_ready,
                                   hold_d, hold_b, hold_id);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || req_ready !== 2'b10) begin
            n_fail++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=10", res_valid, req_ready);
        end
        sb.push_back(mk_exp(32'h20, 32'h20, 1'b1));
        wait_result(2'b00, req_a0, cyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || cyc != 8 || res_data !== e.data || res_borrow !== e.borrow || res_id !== e.id) begin
            n_fail++; $display("FAIL bp_pending: got %h/%b/%b after %0d want %h/%b/%b after 8",
                               res_data, res_borrow, res_id, cyc, e.data, e.borrow, e.id);
        end
    endtask

    task automatic test_capture();
        int   cyc;
        bit   ok;
        exp_t e;
        @(negedge clk);
        req_a0 = 32'h100; req_b0 = 32'h1; req_valid = 2'b01;
        #1;
        sb.push_back(mk_exp(32'h100, 32'h1, 1'b0));
        wait_result(2'b00, 32'hFFFF_FFFF, cyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || res_data !== e.data || res_borrow !== e.borrow || res_id !== e.id) begin
            n_fail++; $display("FAIL capture_result: got %h/%b/%b want %h/%b/%b",
                               res_data, res_borrow, res_id, e.data, e.borrow, e.id);
        end
    endtask

    task automatic test_reset_mid_run();
        int   cyc;
        bit   ok;
        bit   seen;
        exp_t e;
        @(negedge clk);
        req_a1 = 32'h1234_5678; req_b1 = 32'h1; req_valid = 2'b10;
        #1;
        // Aborted operation: nothing is pushed to the scoreboard.
        @(negedge clk);                 // cnt 0
        req_valid = 2'b00;
        repeat (3) @(negedge clk);      // cnt 3 during this cycle
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valid: got %b want 0", res_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (res_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_result: got res_valid seen=%b want 0", seen);
        end
        req_a0 = 32'h9; req_b0 = 32'h2; req_a1 = 32'h5; req_b1 = 32'h1;
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL midrst_tie: got %b want 01", req_ready);
        end
        sb.push_back(mk_exp(32'h9, 32'h2, 1'b0));
        wait_result(2'b00, req_a0, cyc, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || cyc != 8 || res_data !== e.data || res_borrow !== e.borrow || res_id !== e.id) begin
            n_fail++; $display("FAIL midrst_fresh: got %h/%b/%b after %0d want %h/%b/%b after 8",
                               res_data, res_borrow, res_id, cyc, e.data, e.borrow, e.id);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_empty: got %0d left want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_ripple();
        test_round_robin();
        test_back_pressure();
        test_capture();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lea_sub_sched

// File: doc/lea_sub_sched.md
# lea_sub_sched

Nibble-serial 32-bit modular subtraction scheduler for the LEA datapath. The block shares one narrow digit subtractor between two requesters, such as the decryption key-schedule and round units. It arbitrates round-robin, sequences the word through the subtractor least-significant digit first with borrow chaining, and returns difference, final borrow and requester ID over a valid/ready result port.

## Interface
- WORD_W, 32, operand/result width; must be an integer multiple of DIG_W
- DIG_W, 4, width of the shared digit subtractor; NDIG = WORD_W/DIG_W
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; combinational, at most one bit high (one-hot or zero)
- req_a0, req_b0  in  WORD_W  requester 0 minuend / subtrahend
- req_a1, req_b1  in  WORD_W  requester 1 minuend / subtrahend
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  WORD_W  (A − B) mod 2^WORD_W
- res_borrow  out  1  final borrow (1 when A < B unsigned)
- res_id  out  1  index of the requester that issued the result

## Operation
- FSM states IDLE, RUN, DONE.
- IDLE:
  - If any req_valid is high, grant one requester and drive its req_ready high in the same cycle.
  - On the grant edge, capture A and B, clear the borrow and the digit counter, record the ID and go to RUN.
- Arbitration: round-robin on last_grant.
  - If both requesters are valid, grant the one not granted last.
  - If only one is valid, grant it regardless of history.
  - last_grant updates only on an accepted request.
- RUN:
  - Each cycle, digit k = cnt computes {bout, d} = a[k] − b[k] − bin.
  - d is written into result digit k; the borrow register takes bout and cnt increments.
  - After digit NDIG−1, go to DONE with res_borrow = last bout.
- DONE:
  - Hold res_valid, res_data, res_borrow and res_id stable until res_ready.
  - On the res_valid & res_ready edge, drop res_valid and go to IDLE.
- req_ready is 0 in RUN and DONE. No new request is accepted while an operation is in flight or the result is unconsumed.
- Request inputs are sampled only on the grant edge. Later changes do not affect the in-flight operation.
- A requester may drop req_valid before it is granted; no state changes.
- Reset values: state IDLE, res_valid 0, res_data 0, res_borrow 0, res_id 0, cnt 0, borrow 0, last_grant 1 (requester 0 wins the first tie). req_ready is 0 while rst is high.
- rst mid-RUN or mid-DONE aborts the operation. No result is emitted and the operand is lost; the requester must reissue.

## Timing
- Grant edge T: state becomes RUN.
- Edges T+1 … T+NDIG process digits 0 … NDIG−1.
- res_valid is high from the cycle after edge T+NDIG: NDIG cycles after accept, i.e. 8 cycles at the defaults.
- Minimum issue interval is NDIG+2 cycles: NDIG RUN cycles, 1 DONE cycle with res_ready=1, and 1 IDLE grant cycle.
- Back-pressure: each cycle of res_ready=0 in DONE adds one cycle. Result outputs must not change during the stall.
- res_ready is ignored outside DONE.

## Structure
- Shared package lea_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE)
  - LEA_WORD_W = 32 and LEA_DIG_W = 4
  - NDIG, derived from the two constants above
- Sub-module lea_digit_sub holds the DIG_W-bit subtractor: inputs a, b, bin; outputs d, bout. It is purely combinational and instantiated once.
- The arbiter, FSM, counter and shift/index datapath live in lea_sub_sched.

## Test plan
- Reset, then requester 0 issues A=0x00000008, B=0x00000004 → req_ready=2'b01 in the same cycle. After exactly 8 cycles: res_data=0x00000004, res_borrow=0, res_id=0.
- Requester 1 issues A=0x00000000, B=0x00000001 → res_data=0xFFFFFFFF, res_borrow=1, res_id=1. Also covers full borrow ripple across all 8 digits.
- Both requesters valid continuously, three operations (A=0x8, B=0xE and A=0x6, B=0x6 alternating) → grants go 0,1,0. Results 0xFFFFFFFA/borrow 1 and 0x00000000/borrow 0 come back in grant order.
- Hold res_ready=0 for 5 cycles in DONE → res_* stay stable and req_ready stays 2'b00. When res_ready rises, res_valid drops next cycle and a pending request is granted the cycle after.
- Change req_a0 during RUN → result reflects the value captured at grant.
- Assert rst at RUN digit 3 → next cycle state is IDLE, res_valid=0 and no result is produced. A fresh request then completes normally, and requester 0 wins a tie.
